// File: rtl/clk_div_pkg.sv
// Shared constants and divisor helpers for the multi-channel clock divider.
// Helpers work on 32-bit values; callers cast to their own counter width.
package clk_div_pkg;

  localparam int unsigned MIN_DIV       = 2;
  localparam int unsigned DEFAULT_CNT_W = 8;

  // Divisors of 0 or 1 have no meaningful low phase, so they are stored as MIN_DIV.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < MIN_DIV) ? 32'(MIN_DIV) : d;
  endfunction

  // Length of the high phase: ceil(n/2), so odd divisors are high one cycle longer.
  function automatic logic [31:0] half_high(input logic [31:0] n);
    return (n >> 1) + {31'd0, n[0]};
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, pending/active divisor pair, registered clk_out and tick.
// A pending divisor takes effect only at the channel's own wrap, or at once on sync_restart.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = DEFAULT_CNT_W,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_in,
  input  logic             sync_restart,
  output logic             clk_out,
  output logic             tick,
  output logic             div_pending,
  output logic [CNT_W-1:0] active_div
);

  localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(clamp_div(32'(DEFAULT_DIV)));

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] load_div;
  logic [CNT_W-1:0] term;
  logic [CNT_W-1:0] half;
  logic             wrap;

  assign load_div = CNT_W'(clamp_div(32'(div_in)));
  assign term     = active_div - CNT_W'(1);
  assign half     = CNT_W'(half_high(32'(active_div)));
  assign wrap     = en && (cnt == term);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      clk_out     <= 1'b0;
      tick        <= 1'b0;
      div_pending <= 1'b0;
      active_div  <= RESET_DIV;
      pend_div    <= RESET_DIV;
    end else if (sync_restart) begin
      // Restart forces a fresh period; a simultaneous load bypasses the pending stage.
      cnt         <= '0;
      clk_out     <= 1'b0;
      tick        <= 1'b0;
      div_pending <= 1'b0;
      if (div_load) begin
        active_div <= load_div;
        pend_div   <= load_div;
      end else if (div_pending) begin
        active_div <= pend_div;
      end
    end else begin
      if (en) begin
        clk_out <= (cnt < half);
        tick    <= wrap;
        cnt     <= wrap ? '0 : cnt + CNT_W'(1);
      end else begin
        tick    <= 1'b0;
      end
      // The wrap consumes the old pending value; a same-cycle load stays pending.
      if (wrap && div_pending) begin
        active_div  <= pend_div;
        div_pending <= 1'b0;
      end
      if (div_load) begin
        pend_div    <= load_div;
        div_pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider: NUM_CH independent channels sharing
// enable, load and restart controls, each with its own packed divisor slice.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_W       = DEFAULT_CNT_W,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    div_load,
  input  logic [NUM_CH*CNT_W-1:0] div_in,
  input  logic                    sync_restart,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       div_pending,
  output logic [NUM_CH*CNT_W-1:0] active_div
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .div_load     (div_load),
      .div_in       (div_in[k*CNT_W +: CNT_W]),
      .sync_restart (sync_restart),
      .clk_out      (clk_out[k]),
      .tick         (tick[k]),
      .div_pending  (div_pending[k]),
      .active_div   (active_div[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: a period-position reference model predicts each
// cycle's outputs, a monitor compares them one cycle later.
module tb_clk_div_gen;

  localparam int NUM_CH      = 2;
  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 2;
  localparam int DW          = NUM_CH * CNT_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          div_load = 1'b0;
  logic          sync_restart = 1'b0;
  logic [DW-1:0] div_in = '0;
  logic [NUM_CH-1:0] clk_out, tick, div_pending;
  logic [DW-1:0]     active_div;

  always #5 clk = ~clk;

  clk_div_gen #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .div_load     (div_load),
    .div_in       (div_in),
    .sync_restart (sync_restart),
    .clk_out      (clk_out),
    .tick         (tick),
    .div_pending  (div_pending),
    .active_div   (active_div)
  );

  typedef struct packed {
    logic [NUM_CH-1:0] co;
    logic [NUM_CH-1:0] tk;
    logic [NUM_CH-1:0] pf;
    logic [DW-1:0]     ad;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: position inside the current period, period length, queued divisor.
  int m_pos [NUM_CH];
  int m_n   [NUM_CH];
  int m_pend[NUM_CH];
  bit m_pf  [NUM_CH];
  bit m_co  [NUM_CH];
  bit m_tk  [NUM_CH];

  function automatic int clampv(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic model_step(input bit r, input bit e, input bit ld, input bit rs,
                            input logic [DW-1:0] din);
    for (int k = 0; k < NUM_CH; k++) begin
      int v;
      bit last;
      v = clampv(int'(din[k*CNT_W +: CNT_W]));
      if (r) begin
        m_pos[k] = 0; m_n[k] = DEFAULT_DIV; m_pend[k] = DEFAULT_DIV;
        m_pf[k] = 0; m_co[k] = 0; m_tk[k] = 0;
      end else if (rs) begin
        m_pos[k] = 0; m_co[k] = 0; m_tk[k] = 0;
        if (ld) begin
          m_n[k] = v; m_pf[k] = 0;
        end else if (m_pf[k]) begin
          m_n[k] = m_pend[k]; m_pf[k] = 0;
        end
      end else begin
        if (e) begin
          last    = (m_pos[k] == m_n[k] - 1);
          m_co[k] = (m_pos[k] < (m_n[k] + 1) / 2);
          m_tk[k] = last;
          if (last) begin
            m_pos[k] = 0;
            if (m_pf[k]) begin
              m_n[k] = m_pend[k]; m_pf[k] = 0;
            end
          end else begin
            m_pos[k] = m_pos[k] + 1;
          end
        end else begin
          m_tk[k] = 0;
        end
        if (ld) begin
          m_pend[k] = v; m_pf[k] = 1;
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit ld, input bit rs,
                       input logic [DW-1:0] din);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; div_load = ld; sync_restart = rs; div_in = din;
    model_step(r, e, ld, rs, din);
    for (int k = 0; k < NUM_CH; k++) begin
      x.co[k] = m_co[k];
      x.tk[k] = m_tk[k];
      x.pf[k] = m_pf[k];
      x.ad[k*CNT_W +: CNT_W] = CNT_W'(m_n[k]);
    end
    exp_q.push_back(x);
  endtask

  task automatic run(input int n, input bit e);
    for (int i = 0; i < n; i++) drive(1'b0, e, 1'b0, 1'b0, '0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: outputs registered at a posedge are compared 1 ns later.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("clk_out",     32'(clk_out),     32'(x.co));
        check("tick",        32'(tick),        32'(x.tk));
        check("div_pending", 32'(div_pending), 32'(x.pf));
        check("active_div",  32'(active_div),  32'(x.ad));
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    int wait_cnt;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    run(9, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, {8'd5, 8'd3});
    run(30, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, {8'd1, 8'd0});
    run(20, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, {8'd4, 8'd3});
    run(25, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, '0);
    run(12, 1'b1);
    run(3, 1'b1);
    run(5, 1'b0);
    run(10, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, {8'd7, 8'd6});
    run(2, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    run(6, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, {8'd3, 8'd5});
    run(15, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, {8'd4, 8'd4});
    drive(1'b0, 1'b1, 1'b1, 1'b0, {8'd6, 8'd2});
    run(20, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    run(4, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NUM_CH; k++)
        d[k*CNT_W +: CNT_W] = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom_range(0, 255))
                                                          : CNT_W'($urandom_range(0, 9));
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 85),
            ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 3), d);
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
